// File: rtl/pipeline_fetch_unit_pkg.sv
// Shared RV32I fetch definitions: XLEN/NOP/reset-PC macros plus the fetch FIFO payload type.
`ifndef RISCV_CONFIGS_DEFINED
`define RISCV_CONFIGS_DEFINED
`define XLEN 32
`define RISCV_NOP 32'h0000_0013
`define RESET_PC 32'h0000_0000
`endif

package pipeline_fetch_unit_pkg;

    localparam int unsigned XLEN = `XLEN;
    localparam logic [XLEN-1:0] NOP_INSTR   = `RISCV_NOP;
    localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} pairs; flush empties it in one cycle.
module fetch_fifo
    import pipeline_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 2 * XLEN
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata_c,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!i_push && i_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata_c = r_mem[r_rd_ptr];
    assign o_count   = r_count;

endmodule

// File: rtl/pipeline_fetch_unit.sv
// RV32I IF stage: owns the fetch PC, issues credit-limited imem requests and buffers
// in-order responses, discarding those from a path abandoned by a redirect.
module pipeline_fetch_unit
    import pipeline_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = `RESET_PC,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_stall,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic            o_valid,
    output logic [XLEN-1:0] o_instrF,
    output logic [XLEN-1:0] o_PCF,
    output logic [XLEN-1:0] o_PCPlus4F
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [XLEN-1:0]  r_req_pc;
    logic [XLEN-1:0]  r_resp_pc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_kill;

    logic [CNT_W-1:0] w_count;
    logic [SUM_W-1:0] w_committed;
    logic [CNT_W-1:0] w_outstanding_nxt;
    logic             w_req;
    logic             w_hs;
    logic             w_rsp;
    logic             w_push;
    logic             w_pop;
    logic             w_valid;
    fetch_entry_t     w_wdata;
    fetch_entry_t     w_head;

    // Live in-flight responses plus buffered entries must fit the FIFO before asking again.
    assign w_committed = SUM_W'(r_outstanding - r_kill) + SUM_W'(w_count);
    assign w_req       = i_rstn && !i_redirect
                         && (r_outstanding < CNT_W'(DEPTH))
                         && (w_committed < SUM_W'(DEPTH));
    assign w_hs        = w_req && i_imem_gnt;
    assign w_rsp       = i_imem_rvalid && (r_outstanding != '0);
    assign w_push      = w_rsp && (r_kill == '0) && !i_redirect;
    assign w_valid     = (w_count != '0) && !i_redirect;
    assign w_pop       = w_valid && !i_stall;

    assign w_outstanding_nxt = r_outstanding + CNT_W'(w_hs) - CNT_W'(w_rsp);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_req_pc      <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_kill        <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            if (i_redirect) begin
                r_req_pc  <= word_align(i_redirect_pc);
                r_resp_pc <= word_align(i_redirect_pc);
                r_kill    <= w_outstanding_nxt;
            end else begin
                if (w_hs) begin
                    r_req_pc <= r_req_pc + INSTR_BYTES;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + INSTR_BYTES;
                end
                if (w_rsp && (r_kill != '0)) begin
                    r_kill <= r_kill - CNT_W'(1);
                end
            end
        end
    end

    assign w_wdata = '{pc: r_resp_pc, instr: i_imem_rdata};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_flush   (i_redirect),
        .i_wdata   (w_wdata),
        .o_rdata_c (w_head),
        .o_count   (w_count)
    );

    assign o_imem_req  = w_req;
    assign o_imem_addr = r_req_pc;
    assign o_valid     = w_valid;
    assign o_instrF    = w_valid ? w_head.instr : NOP_INSTR;
    assign o_PCF       = w_valid ? w_head.pc : '0;
    assign o_PCPlus4F  = w_valid ? (w_head.pc + INSTR_BYTES) : '0;

endmodule
